// File: rtl/bbox_tracker_pkg.sv
// Shared types and helpers for the streaming bounding-box tracker.
// Coordinates are carried at MAX_CW bits here and narrowed to CW inside the tracker.
package bbox_pkg;

   localparam int unsigned MAX_CW = 16;

   typedef logic [1:0] state_t;
   localparam state_t IDLE  = 2'd0;
   localparam state_t ACCUM = 2'd1;
   localparam state_t DONE  = 2'd2;

   typedef struct packed {
      logic [MAX_CW-1:0] xmin;
      logic [MAX_CW-1:0] xmax;
      logic [MAX_CW-1:0] ymin;
      logic [MAX_CW-1:0] ymax;
   } box_t;

   function automatic int unsigned coord_w(int unsigned w, int unsigned h);
      int unsigned cw;
      cw = $clog2((w > h) ? w : h);
      return (cw == 0) ? 1 : cw;
   endfunction

   // Inverted extremes: the first foreground pixel overwrites all four fields.
   function automatic box_t box_reset(int unsigned w, int unsigned h);
      box_t b;
      b.xmin = MAX_CW'(w - 1);
      b.xmax = '0;
      b.ymin = MAX_CW'(h - 1);
      b.ymax = '0;
      return b;
   endfunction

endpackage

// File: rtl/bbox_tracker_if.sv
// Pixel-stream input, result handshake and status signals of the bounding-box tracker.
interface bbox_tracker_if #(
   parameter int unsigned WIDTH  = 100,
   parameter int unsigned HEIGHT = 100
);
   localparam int unsigned CW   = bbox_pkg::coord_w(WIDTH, HEIGHT);
   localparam int unsigned CNTW = $clog2(WIDTH * HEIGHT + 1);

   logic            start;
   logic            px_valid;
   logic            px_ready;
   logic [7:0]      px_data;
   logic            res_valid;
   logic            res_ready;
   logic [4*CW-1:0] box;
   logic            box_empty;
   logic [CNTW-1:0] fg_count;
   logic            busy;

   modport master (
      output start, px_valid, px_data, res_ready,
      input  px_ready, res_valid, box, box_empty, fg_count, busy
   );

   modport slave (
      input  start, px_valid, px_data, res_ready,
      output px_ready, res_valid, box, box_empty, fg_count, busy
   );
endinterface

// File: rtl/bbox_tracker_raster_counter.sv
// Channel / column / row position counters for a raster stream of multi-byte pixels.
module bbox_raster_counter #(
   parameter int unsigned WIDTH     = 100,
   parameter int unsigned HEIGHT    = 100,
   parameter int unsigned CHANNELS  = 3,
   parameter int unsigned BOTTOM_UP = 1,
   parameter int unsigned CW        = 7
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic          adv_i,
   output logic [CW-1:0] x_o,
   output logic [CW-1:0] y_o,
   output logic          pix_done_o,
   output logic          frame_last_o
);
   localparam int unsigned CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [CHW-1:0] ChLast = CHW'(CHANNELS - 1);
   localparam logic [CW-1:0]  XLast  = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  YFirst = (BOTTOM_UP != 0) ? CW'(HEIGHT - 1) : CW'(0);
   localparam logic [CW-1:0]  YLast  = (BOTTOM_UP != 0) ? CW'(0) : CW'(HEIGHT - 1);

   logic [CHW-1:0] ch_q, ch_d;
   logic [CW-1:0]  x_q, x_d;
   logic [CW-1:0]  y_q, y_d;

   always_comb begin
      ch_d = ch_q;
      x_d  = x_q;
      y_d  = y_q;
      if (start_i) begin
         ch_d = '0;
         x_d  = '0;
         y_d  = YFirst;
      end else if (adv_i) begin
         if (ch_q != ChLast) begin
            ch_d = ch_q + CHW'(1);
         end else begin
            ch_d = '0;
            if (x_q == XLast) begin
               x_d = '0;
               y_d = (BOTTOM_UP != 0) ? y_q - CW'(1) : y_q + CW'(1);
            end else begin
               x_d = x_q + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ch_q <= '0;
         x_q  <= '0;
         y_q  <= YFirst;
      end else begin
         ch_q <= ch_d;
         x_q  <= x_d;
         y_q  <= y_d;
      end
   end

   assign x_o          = x_q;
   assign y_o          = y_q;
   assign pix_done_o   = (ch_q == ChLast);
   assign frame_last_o = (x_q == XLast) && (y_q == YLast);
endmodule

// File: rtl/bbox_tracker.sv
// Streaming bounding-box tracker: flags dark pixels, accumulates extremes and count,
// and holds the frame result until the host accepts it.
module bbox_tracker
   import bbox_pkg::*;
#(
   parameter int unsigned WIDTH     = 100,
   parameter int unsigned HEIGHT    = 100,
   parameter int unsigned CHANNELS  = 3,
   parameter int unsigned THRESH    = 250,
   parameter int unsigned BOTTOM_UP = 1
) (
   input logic            CLOCK_50,
   input logic            reset,
   bbox_tracker_if.slave  bus
);
   localparam int unsigned CW   = coord_w(WIDTH, HEIGHT);
   localparam int unsigned CNTW = $clog2(WIDTH * HEIGHT + 1);
   localparam box_t        BoxRst  = box_reset(WIDTH, HEIGHT);
   localparam logic [8:0]  ThreshW = 9'(THRESH);

   typedef struct packed {
      logic [CW-1:0] xmin;
      logic [CW-1:0] xmax;
      logic [CW-1:0] ymin;
      logic [CW-1:0] ymax;
   } cbox_t;

   localparam cbox_t CBoxRst = '{xmin: BoxRst.xmin[CW-1:0], xmax: BoxRst.xmax[CW-1:0],
                                 ymin: BoxRst.ymin[CW-1:0], ymax: BoxRst.ymax[CW-1:0]};

   state_t          state_q, state_d;
   logic            fg_q, fg_d;
   cbox_t           box_q, box_d;
   logic            empty_q, empty_d;
   logic [CNTW-1:0] count_q, count_d;

   logic [CW-1:0] x, y;
   logic          pix_done, frame_last, transfer, fg_pix;

   assign bus.px_ready = (state_q == ACCUM) && !bus.start;
   assign transfer     = bus.px_valid && bus.px_ready;
   assign fg_pix       = fg_q || ({1'b0, bus.px_data} < ThreshW);

   bbox_raster_counter #(
      .WIDTH     (WIDTH),
      .HEIGHT    (HEIGHT),
      .CHANNELS  (CHANNELS),
      .BOTTOM_UP (BOTTOM_UP),
      .CW        (CW)
   ) u_raster (
      .clk_i        (CLOCK_50),
      .rst_i        (reset),
      .start_i      (bus.start),
      .adv_i        (transfer),
      .x_o          (x),
      .y_o          (y),
      .pix_done_o   (pix_done),
      .frame_last_o (frame_last)
   );

   always_comb begin
      state_d = state_q;
      fg_d    = fg_q;
      box_d   = box_q;
      empty_d = empty_q;
      count_d = count_q;
      if (bus.start) begin
         state_d = ACCUM;
         fg_d    = 1'b0;
         box_d   = CBoxRst;
         empty_d = 1'b1;
         count_d = '0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (transfer) begin
                  if (pix_done) begin
                     fg_d = 1'b0;
                     if (fg_pix) begin
                        if (x < box_q.xmin) box_d.xmin = x;
                        if (x > box_q.xmax) box_d.xmax = x;
                        if (y < box_q.ymin) box_d.ymin = y;
                        if (y > box_q.ymax) box_d.ymax = y;
                        empty_d = 1'b0;
                        count_d = count_q + CNTW'(1);
                     end
                     if (frame_last) state_d = DONE;
                  end else begin
                     fg_d = fg_pix;
                  end
               end
            end
            DONE: begin
               if (bus.res_ready) state_d = IDLE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= IDLE;
         fg_q    <= 1'b0;
         box_q   <= CBoxRst;
         empty_q <= 1'b1;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         fg_q    <= fg_d;
         box_q   <= box_d;
         empty_q <= empty_d;
         count_q <= count_d;
      end
   end

   assign bus.res_valid = (state_q == DONE);
   assign bus.busy      = (state_q == ACCUM);
   assign bus.box       = box_q;
   assign bus.box_empty = empty_q;
   assign bus.fg_count  = count_q;
endmodule

// File: tb/tb_bbox_tracker.sv
// Directed bench: a bottom-up and a top-down 4x4x3 tracker share one stimulus stream.
module tb_bbox_tracker;
   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   bbox_tracker_if #(.WIDTH(4), .HEIGHT(4)) bus_bu ();
   bbox_tracker_if #(.WIDTH(4), .HEIGHT(4)) bus_td ();

   bbox_tracker #(
      .WIDTH(4), .HEIGHT(4), .CHANNELS(3), .THRESH(250), .BOTTOM_UP(1)
   ) dut_bu (
      .CLOCK_50 (clk),
      .reset    (reset),
      .bus      (bus_bu)
   );

   bbox_tracker #(
      .WIDTH(4), .HEIGHT(4), .CHANNELS(3), .THRESH(250), .BOTTOM_UP(0)
   ) dut_td (
      .CLOCK_50 (clk),
      .reset    (reset),
      .bus      (bus_td)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] bx(input int a, input int b, input int c, input int d);
      return {a[1:0], b[1:0], c[1:0], d[1:0]};
   endfunction

   // Foreground pixels carry a dark middle channel; all other bytes are white.
   function automatic logic [7:0] byte_of(input logic [15:0] mask, input int idx);
      return (mask[idx / 3] && (idx % 3 == 1)) ? 8'd10 : 8'd255;
   endfunction

   task automatic drive(input logic st, input logic v, input logic [7:0] d);
      bus_bu.start = st;  bus_td.start = st;
      bus_bu.px_valid = v; bus_td.px_valid = v;
      bus_bu.px_data = d;  bus_td.px_data = d;
   endtask

   task automatic set_rr(input logic r);
      bus_bu.res_ready = r;
      bus_td.res_ready = r;
   endtask

   task automatic pulse_start;
      drive(1'b1, 1'b0, 8'h00);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 8'h00);
   endtask

   // Feed bytes first..last-1 of a frame; idle beats (toggle) carry idle_byte.
   task automatic feed(input logic [15:0] mask, input bit toggle, input int first,
                       input int last, input logic [7:0] idle_byte);
      int   idx = first;
      int   cyc = 0;
      logic v;
      logic rdy;
      while (idx < last && cyc < 500) begin
         v = toggle ? (cyc % 2 == 0) : 1'b1;
         drive(1'b0, v, v ? byte_of(mask, idx) : idle_byte);
         #1;
         rdy = bus_bu.px_ready;
         @(posedge clk); #1;
         if (v && rdy) idx++;
         cyc++;
      end
      drive(1'b0, 1'b0, 8'h00);
      check("feed_accept", 32'(idx), 32'(last));
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 8'h00);
      set_rr(1'b1);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      check("rst_px_ready", 32'(bus_bu.px_ready), 32'd0);
      check("rst_res_valid", 32'(bus_bu.res_valid), 32'd0);
      check("rst_box", 32'(bus_bu.box), 32'(bx(3, 0, 3, 0)));
      check("rst_empty", 32'(bus_bu.box_empty), 32'd1);
      check("rst_count", 32'(bus_bu.fg_count), 32'd0);
      check("rst_busy", 32'(bus_bu.busy), 32'd0);

      // Empty frame: result appears exactly one cycle after the 48th byte.
      pulse_start();
      feed(16'h0000, 1'b0, 0, 47, 8'h00);
      check("t1_not_early", 32'(bus_bu.res_valid), 32'd0);
      check("t1_busy", 32'(bus_bu.busy), 32'd1);
      feed(16'h0000, 1'b0, 47, 48, 8'h00);
      check("t1_res_valid", 32'(bus_bu.res_valid), 32'd1);
      check("t1_box", 32'(bus_bu.box), 32'(bx(3, 0, 3, 0)));
      check("t1_empty", 32'(bus_bu.box_empty), 32'd1);
      check("t1_count", 32'(bus_bu.fg_count), 32'd0);
      @(posedge clk); #1;
      check("t1_idle", 32'({bus_bu.res_valid, bus_bu.busy, bus_bu.px_ready}), 32'd0);

      // Pixels 5 and 10.
      pulse_start();
      feed(16'h0420, 1'b0, 0, 48, 8'h00);
      check("t2_res_valid", 32'(bus_bu.res_valid), 32'd1);
      check("t2_box_bu", 32'(bus_bu.box), 32'(bx(1, 2, 1, 2)));
      check("t2_box_td", 32'(bus_td.box), 32'(bx(1, 2, 1, 2)));
      check("t2_count", 32'(bus_bu.fg_count), 32'd2);
      check("t2_empty", 32'(bus_bu.box_empty), 32'd0);
      @(posedge clk); #1;

      // All foreground with gapped valid.
      pulse_start();
      feed(16'hFFFF, 1'b1, 0, 48, 8'h00);
      check("t3_res_valid", 32'(bus_bu.res_valid), 32'd1);
      check("t3_box", 32'(bus_bu.box), 32'(bx(0, 3, 0, 3)));
      check("t3_count", 32'(bus_bu.fg_count), 32'd16);
      @(posedge clk); #1;

      // White frame with dark bytes on invalid beats only.
      pulse_start();
      feed(16'h0000, 1'b1, 0, 48, 8'h00);
      check("t3b_empty", 32'(bus_bu.box_empty), 32'd1);
      check("t3b_count", 32'(bus_bu.fg_count), 32'd0);
      check("t3b_box", 32'(bus_bu.box), 32'(bx(3, 0, 3, 0)));
      @(posedge clk); #1;

      // Restart mid-frame.
      pulse_start();
      feed(16'hFFFF, 1'b0, 0, 20, 8'h00);
      check("t4_partial_count", 32'(bus_bu.fg_count), 32'd6);
      drive(1'b1, 1'b1, 8'd10);
      #1;
      check("t4_start_no_ready", 32'(bus_bu.px_ready), 32'd0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 8'h00);
      check("t4_cleared_count", 32'(bus_bu.fg_count), 32'd0);
      check("t4_cleared_box", 32'(bus_bu.box), 32'(bx(3, 0, 3, 0)));
      feed(16'h0001, 1'b0, 0, 48, 8'h00);
      check("t4_box_bu", 32'(bus_bu.box), 32'(bx(0, 0, 3, 3)));
      check("t4_box_td", 32'(bus_td.box), 32'(bx(0, 0, 0, 0)));
      check("t4_count", 32'(bus_bu.fg_count), 32'd1);
      @(posedge clk); #1;

      // Host stalls the result; bytes offered in DONE must be refused.
      set_rr(1'b0);
      pulse_start();
      feed(16'h8000, 1'b0, 0, 48, 8'h00);
      check("t5_box_bu", 32'(bus_bu.box), 32'(bx(3, 3, 0, 0)));
      check("t5_box_td", 32'(bus_td.box), 32'(bx(3, 3, 3, 3)));
      drive(1'b0, 1'b1, 8'd0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("t5_hold", 32'({bus_bu.res_valid, bus_bu.px_ready, bus_bu.box}),
               32'({1'b1, 1'b0, bx(3, 3, 0, 0)}));
      end
      drive(1'b0, 1'b0, 8'h00);
      check("t5_count_held", 32'(bus_bu.fg_count), 32'd1);
      set_rr(1'b1);
      @(posedge clk); #1;
      check("t5_idle", 32'({bus_bu.res_valid, bus_bu.busy}), 32'd0);
      check("t5_box_kept", 32'(bus_bu.box), 32'(bx(3, 3, 0, 0)));
      check("t5_count_kept", 32'(bus_bu.fg_count), 32'd1);

      // Start while a result is pending discards it.
      set_rr(1'b0);
      pulse_start();
      feed(16'h0001, 1'b0, 0, 48, 8'h00);
      check("t6_pending", 32'(bus_bu.res_valid), 32'd1);
      pulse_start();
      check("t6_dropped", 32'({bus_bu.res_valid, bus_bu.busy}), 32'b01);
      check("t6_count", 32'(bus_bu.fg_count), 32'd0);
      set_rr(1'b1);

      // Reset mid-frame.
      feed(16'hFFFF, 1'b0, 0, 12, 8'h00);
      check("t7_partial", 32'(bus_bu.fg_count), 32'd4);
      reset = 1'b1;
      @(posedge clk); #1;
      check("t7_busy", 32'({bus_bu.busy, bus_bu.px_ready, bus_bu.res_valid}), 32'd0);
      check("t7_box", 32'(bus_bu.box), 32'(bx(3, 0, 3, 0)));
      check("t7_empty", 32'(bus_bu.box_empty), 32'd1);
      check("t7_count", 32'(bus_bu.fg_count), 32'd0);
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
